// File: rtl/video_pkg.sv
// Shared video timing definitions: default 640x480@60 constants, colour and timing
// bundle types, and the frame/line total helper.
package video_pkg;

  localparam int unsigned VgaHActive      = 640;
  localparam int unsigned VgaHFrontPorch  = 16;
  localparam int unsigned VgaHSync        = 96;
  localparam int unsigned VgaHBackPorch   = 48;
  localparam int unsigned VgaVActive      = 480;
  localparam int unsigned VgaVFrontPorch  = 10;
  localparam int unsigned VgaVSync        = 2;
  localparam int unsigned VgaVBackPorch   = 33;
  localparam int unsigned ColorW          = 4;

  typedef struct packed {
    logic [ColorW-1:0] r;
    logic [ColorW-1:0] g;
    logic [ColorW-1:0] b;
  } rgb_t;

  // Raw (asserted = 1) timing flags carried down the pixel pipeline.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
  } timing_t;

  function automatic int unsigned calc_total(input int unsigned active,
                                             input int unsigned front_porch,
                                             input int unsigned sync,
                                             input int unsigned back_porch);
    return active + front_porch + sync + back_porch;
  endfunction

endpackage

// File: rtl/video_delay_line.sv
// Enable-gated shift register; each stage advances only when en_i is high.
module video_delay_line #(
  parameter int unsigned           WIDTH     = 1,
  parameter int unsigned           DEPTH     = 1,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH < 1) begin : g_depth_chk
    $error("video_delay_line: DEPTH must be at least 1");
  end

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d = stage_q;
    if (en_i) begin
      stage_d[0] = d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/video_vga_timing_gen.sv
// Parametrised VGA timing generator: x/y counters on a pixel enable, renderer strobes,
// and a pipeline-aligned RGB/sync output register.
module video_vga_timing_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = VgaHActive,
  parameter int unsigned H_FRONT_PORCH   = VgaHFrontPorch,
  parameter int unsigned H_SYNC          = VgaHSync,
  parameter int unsigned H_BACK_PORCH    = VgaHBackPorch,
  parameter int unsigned V_ACTIVE        = VgaVActive,
  parameter int unsigned V_FRONT_PORCH   = VgaVFrontPorch,
  parameter int unsigned V_SYNC          = VgaVSync,
  parameter int unsigned V_BACK_PORCH    = VgaVBackPorch,
  parameter logic        HSYNC_POL       = 1'b0,
  parameter logic        VSYNC_POL       = 1'b0,
  parameter int unsigned COLOR_W         = ColorW,
  parameter int unsigned PIPE_DELAY      = 2,
  parameter int unsigned PRERENDER_LINES = 1,
  parameter int unsigned CNT_W           = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pix_ce,
  input  logic                 display_en,
  input  logic [3*COLOR_W-1:0] border_rgb,
  input  logic [3*COLOR_W-1:0] palette_rgb_data,
  input  logic [CNT_W-1:0]     irq_line,
  input  logic                 irq_en,
  output logic [CNT_W-1:0]     display_line_idx,
  output logic                 next_frame,
  output logic                 next_line,
  output logic                 next_pixel,
  output logic                 vblank_pulse,
  output logic                 line_irq,
  output logic [7:0]           frame_cnt,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 vga_hsync,
  output logic                 vga_vsync
);

  localparam int unsigned H_TOTAL =
      calc_total(H_ACTIVE, H_FRONT_PORCH, H_SYNC, H_BACK_PORCH);
  localparam int unsigned V_TOTAL =
      calc_total(V_ACTIVE, V_FRONT_PORCH, V_SYNC, V_BACK_PORCH);

  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_cnt_w_chk
    $error("video_vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
  end
  if (PRERENDER_LINES >= V_TOTAL || PIPE_DELAY < 1) begin : g_param_chk
    $error("video_vga_timing_gen: bad PRERENDER_LINES or PIPE_DELAY");
  end

  localparam logic [CNT_W-1:0] XLast   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] YLast   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] YFrame  = CNT_W'(V_TOTAL - 1 - PRERENDER_LINES);
  localparam logic [CNT_W-1:0] YVblank = CNT_W'(V_ACTIVE - 1);
  // One extra bit so window ends equal to 2**CNT_W still compare correctly.
  localparam logic [CNT_W:0]   XActEnd = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0]   HsStart = (CNT_W+1)'(H_ACTIVE + H_FRONT_PORCH);
  localparam logic [CNT_W:0]   HsEnd   = (CNT_W+1)'(H_ACTIVE + H_FRONT_PORCH + H_SYNC);
  localparam logic [CNT_W:0]   YActEnd = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0]   VsStart = (CNT_W+1)'(V_ACTIVE + V_FRONT_PORCH);
  localparam logic [CNT_W:0]   VsEnd   = (CNT_W+1)'(V_ACTIVE + V_FRONT_PORCH + V_SYNC);

  logic [CNT_W-1:0]     x_q, x_d, y_q, y_d, line_idx_q, line_idx_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;
  logic                 hsync_q, hsync_d, vsync_q, vsync_d;
  logic [CNT_W:0]       x_ext, y_ext;
  logic                 h_last;
  timing_t              raw, dly;

  assign x_ext = {1'b0, x_q};
  assign y_ext = {1'b0, y_q};

  assign h_last       = pix_ce && (x_q == XLast);
  assign next_line    = h_last;
  assign next_frame   = h_last && (y_q == YFrame);
  assign vblank_pulse = h_last && (y_q == YVblank);
  assign line_irq     = irq_en && pix_ce && (x_ext == XActEnd) && (y_q == irq_line);
  assign next_pixel   = pix_ce;

  assign raw.hsync  = (x_ext >= HsStart) && (x_ext < HsEnd);
  assign raw.vsync  = (y_ext >= VsStart) && (y_ext < VsEnd);
  assign raw.active = (x_ext < XActEnd) && (y_ext < YActEnd);

  video_delay_line #(
    .WIDTH     ($bits(timing_t)),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL ('0)
  ) u_timing_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (pix_ce),
    .d_i   (raw),
    .q_o   (dly)
  );

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    line_idx_d  = line_idx_q;
    frame_cnt_d = frame_cnt_q;
    rgb_d       = rgb_q;
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    if (pix_ce) begin
      x_d = h_last ? '0 : x_q + 1'b1;
      if (h_last) begin
        y_d = (y_q == YLast) ? '0 : y_q + 1'b1;
      end
      if (!dly.active) begin
        rgb_d = '0;
      end else if (display_en) begin
        rgb_d = palette_rgb_data;
      end else begin
        rgb_d = border_rgb;
      end
      hsync_d = dly.hsync ? HSYNC_POL : ~HSYNC_POL;
      vsync_d = dly.vsync ? VSYNC_POL : ~VSYNC_POL;
    end
    if (next_line) begin
      line_idx_d = next_frame ? '0 : line_idx_q + 1'b1;
    end
    if (vblank_pulse) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      line_idx_q  <= '0;
      frame_cnt_q <= '0;
      rgb_q       <= '0;
      hsync_q     <= ~HSYNC_POL;
      vsync_q     <= ~VSYNC_POL;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      line_idx_q  <= line_idx_d;
      frame_cnt_q <= frame_cnt_d;
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end

  assign display_line_idx = line_idx_q;
  assign frame_cnt        = frame_cnt_q;
  assign vga_r            = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign vga_g            = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign vga_b            = rgb_q[COLOR_W-1 -: COLOR_W];
  assign vga_hsync        = hsync_q;
  assign vga_vsync        = vsync_q;

endmodule

// File: tb/tb_video_vga_timing_gen.sv
// Directed bench for video_vga_timing_gen on a reduced 24x15 timing so frames stay short.
module tb_video_vga_timing_gen;
  import video_pkg::*;

  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 8, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;  // 24
  localparam int VT = VA + VFP + VS + VBP;  // 15
  localparam int PRE = 1;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pix_ce;
  logic          display_en;
  logic [11:0]   border_rgb;
  logic [11:0]   palette_rgb_data;
  logic [CW-1:0] irq_line;
  logic          irq_en;
  logic [CW-1:0] display_line_idx;
  logic          next_frame, next_line, next_pixel, vblank_pulse, line_irq;
  logic [7:0]    frame_cnt;
  logic [3:0]    vga_r, vga_g, vga_b;
  logic          vga_hsync, vga_vsync;

  video_vga_timing_gen #(
    .H_ACTIVE        (HA),
    .H_FRONT_PORCH   (HFP),
    .H_SYNC          (HS),
    .H_BACK_PORCH    (HBP),
    .V_ACTIVE        (VA),
    .V_FRONT_PORCH   (VFP),
    .V_SYNC          (VS),
    .V_BACK_PORCH    (VBP),
    .HSYNC_POL       (1'b1),
    .VSYNC_POL       (1'b0),
    .COLOR_W         (4),
    .PIPE_DELAY      (2),
    .PRERENDER_LINES (PRE),
    .CNT_W           (CW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pix_ce           (pix_ce),
    .display_en       (display_en),
    .border_rgb       (border_rgb),
    .palette_rgb_data (palette_rgb_data),
    .irq_line         (irq_line),
    .irq_en           (irq_en),
    .display_line_idx (display_line_idx),
    .next_frame       (next_frame),
    .next_line        (next_line),
    .next_pixel       (next_pixel),
    .vblank_pulse     (vblank_pulse),
    .line_irq         (line_irq),
    .frame_cnt        (frame_cnt),
    .vga_r            (vga_r),
    .vga_g            (vga_g),
    .vga_b            (vga_b),
    .vga_hsync        (vga_hsync),
    .vga_vsync        (vga_vsync)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  // Bench-side reference position and counters.
  int bx, by, exp_idx, exp_fc, irq_count;

  typedef struct {
    int   y;
    int   x;
    bit   den;
    bit   hs;
    bit   vs;
    rgb_t rgb;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (y=%0d x=%0d t=%0t)", name, act, exp, by, bx,
               $time);
    end
  endtask

  task automatic chk_pins(input string name, input bit hs, input bit vs, input rgb_t rgb);
    chk({name, "_hsync"}, 32'(vga_hsync), 32'(hs));
    chk({name, "_vsync"}, 32'(vga_vsync), 32'(vs));
    chk({name, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'(rgb));
  endtask

  // Advance n clocks from a negedge, checking strobes against the reference each clock.
  task automatic run(input int n, input bit toggle);
    int last_nl = -1;
    int hs_run = -1;
    bit hl, nf, vb, irq;
    for (int i = 0; i < n; i++) begin
      pix_ce = toggle ? ((i % 2) == 0) : 1'b1;
      #1;
      hl  = pix_ce && (bx == HT - 1);
      nf  = hl && (by == VT - 1 - PRE);
      vb  = hl && (by == VA - 1);
      irq = irq_en && pix_ce && (bx == HA) && (by == int'(irq_line));
      chk("next_pixel", 32'(next_pixel), 32'(pix_ce));
      chk("next_line", 32'(next_line), 32'(hl));
      chk("next_frame", 32'(next_frame), 32'(nf));
      chk("vblank_pulse", 32'(vblank_pulse), 32'(vb));
      chk("line_irq", 32'(line_irq), 32'(irq));
      chk("line_idx", 32'(display_line_idx), 32'(exp_idx));
      chk("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
      if (line_irq === 1'b1) irq_count++;
      if (hl) begin
        if (last_nl >= 0) chk("line_period", 32'(cyc - last_nl), 32'(toggle ? 2 * HT : HT));
        last_nl = cyc;
      end
      if (vga_hsync === 1'b1) begin
        if (hs_run >= 0) hs_run++;
      end else begin
        if (hs_run > 0) chk("hsync_width", 32'(hs_run), 32'(toggle ? 2 * HS : HS));
        hs_run = 0;
      end
      if (pix_ce) begin
        if (hl) begin
          exp_idx = nf ? 0 : (exp_idx + 1) % (1 << CW);
          bx = 0;
          by = (by == VT - 1) ? 0 : by + 1;
        end else begin
          bx++;
        end
        if (vb) exp_fc = (exp_fc + 1) % 256;
      end
      @(negedge clk);
    end
  endtask

  task automatic goto_pos(input int ty, input int tx);
    int guard = 0;
    while (!(by == ty && bx == tx) && guard < 2 * HT * VT) begin
      run(1, 1'b0);
      guard++;
    end
    if (guard >= 2 * HT * VT) begin
      checks++;
      errors++;
      $display("FAIL goto_pos: position y=%0d x=%0d not reached", ty, tx);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_pins("reset", 1'b0, 1'b1, 12'h000);
    chk("reset_line_idx", 32'(display_line_idx), 32'd0);
    chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("reset_pulses", 32'({next_line, next_frame, vblank_pulse, line_irq}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bx = 0;
    by = 0;
    exp_idx = 0;
    exp_fc = 0;
  endtask

  initial begin
    // y, x, display_en, expected hsync, vsync, rgb (pins show pixel 3 steps behind counter)
    tbl[0]  = '{0, 0, 1'b1, 1'b0, 1'b1, 12'h000};
    tbl[1]  = '{0, 2, 1'b1, 1'b0, 1'b1, 12'h000};
    tbl[2]  = '{0, 3, 1'b1, 1'b0, 1'b1, 12'h123};
    tbl[3]  = '{0, 4, 1'b0, 1'b0, 1'b1, 12'hF00};
    tbl[4]  = '{0, 19, 1'b1, 1'b0, 1'b1, 12'h000};
    tbl[5]  = '{0, 21, 1'b1, 1'b1, 1'b1, 12'h000};
    tbl[6]  = '{0, 23, 1'b1, 1'b1, 1'b1, 12'h000};
    tbl[7]  = '{1, 0, 1'b1, 1'b0, 1'b1, 12'h000};
    tbl[8]  = '{1, 18, 1'b1, 1'b0, 1'b1, 12'h123};
    tbl[9]  = '{1, 19, 1'b0, 1'b0, 1'b1, 12'h000};
    tbl[10] = '{8, 3, 1'b0, 1'b0, 1'b1, 12'h000};
    tbl[11] = '{10, 2, 1'b0, 1'b0, 1'b1, 12'h000};
    tbl[12] = '{10, 3, 1'b0, 1'b0, 1'b0, 12'h000};
    tbl[13] = '{11, 23, 1'b0, 1'b1, 1'b0, 12'h000};
    tbl[14] = '{12, 2, 1'b0, 1'b0, 1'b0, 12'h000};
    tbl[15] = '{12, 3, 1'b0, 1'b0, 1'b1, 12'h000};
    tbl[16] = '{0, 3, 1'b1, 1'b0, 1'b1, 12'h123};
    tbl[17] = '{0, 4, 1'b0, 1'b0, 1'b1, 12'hF00};
    tbl[18] = '{0, 5, 1'b1, 1'b0, 1'b1, 12'h123};

    rst_n            = 1'b0;
    pix_ce           = 1'b1;
    display_en       = 1'b1;
    border_rgb       = 12'hF00;
    palette_rgb_data = 12'h123;
    irq_line         = CW'(5);
    irq_en           = 1'b1;
    irq_count        = 0;
    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      display_en = tbl[i].den;
      goto_pos(tbl[i].y, tbl[i].x);
      chk_pins($sformatf("vec%0d", i), tbl[i].hs, tbl[i].vs, tbl[i].rgb);
    end

    // Two whole frames from reset: strobes, line index, frame count, one irq per frame.
    do_reset();
    irq_count = 0;
    run(2 * HT * VT, 1'b0);
    chk("irq_per_2_frames", 32'(irq_count), 32'd2);
    chk("frame_cnt_2", 32'(frame_cnt), 32'd2);

    irq_en = 1'b0;
    irq_count = 0;
    run(HT * VT, 1'b0);
    chk("irq_disabled", 32'(irq_count), 32'd0);

    irq_en = 1'b1;
    irq_line = CW'(20);
    irq_count = 0;
    run(HT * VT, 1'b0);
    chk("irq_line_out_of_range", 32'(irq_count), 32'd0);

    // Half-rate pixel enable: periods double, strobes stay single-clock.
    irq_line = CW'(5);
    irq_count = 0;
    run(2 * 2 * HT * VT, 1'b1);
    chk("irq_half_rate", 32'(irq_count), 32'd2);

    // Reset in the middle of an active line, then the first vblank after release.
    display_en = 1'b1;
    goto_pos(3, 10);
    chk_pins("pre_reset", 1'b0, 1'b1, 12'h123);
    do_reset();
    run(VA * HT, 1'b0);
    chk("frame_cnt_after_reset", 32'(frame_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
